// File: rtl/mestpro_mem_arbiter_if.sv
// Signal bundle between the two requesting ports, the arbiter and the MESTPro
// memory macro. The arbiter uses the slave view and its environment uses the master view.
interface mestpro_mem_arbiter_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    // Handshake: a port raises reqN with weN/addrN/wdatN stable and holds them
    // until ackN pulses for one cycle. rdatN is valid on that pulse for a read
    // and holds until that port's next read.
    logic                 req0;
    logic                 we0;
    logic [ADDR_BITS-1:0] addr0;
    logic [DATA_BITS-1:0] wdat0;
    logic                 ack0;
    logic [DATA_BITS-1:0] rdat0;

    logic                 req1;
    logic                 we1;
    logic [ADDR_BITS-1:0] addr1;
    logic [DATA_BITS-1:0] wdat1;
    logic                 ack1;
    logic [DATA_BITS-1:0] rdat1;

    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] in_dat;
    logic                 WE;
    logic                 CS;
    logic [DATA_BITS-1:0] o_dat;

    logic [1:0]           dbg_state;

    modport slave (
        input  req0, we0, addr0, wdat0,
        output ack0, rdat0,
        input  req1, we1, addr1, wdat1,
        output ack1, rdat1,
        output addr, in_dat, WE, CS,
        input  o_dat,
        output dbg_state
    );

    modport master (
        output req0, we0, addr0, wdat0,
        input  ack0, rdat0,
        output req1, we1, addr1, wdat1,
        input  ack1, rdat1,
        input  addr, in_dat, WE, CS,
        output o_dat,
        input  dbg_state
    );
endinterface

// File: rtl/mestpro_mem_arbiter.sv
// Round-robin arbiter that serialises two single-word request ports onto the
// MESTPro memory macro: one CS pulse per granted access, one ack per access.
module mestpro_mem_arbiter #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    mestpro_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t               state_q, state_d;
    logic                 gnt_q, gnt_d;
    logic                 last_gnt_q, last_gnt_d;
    logic                 gnt_sel;
    logic [1:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] in_dat_q, in_dat_d;
    logic                 we_q, we_d;
    logic                 cs_q, cs_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic [DATA_BITS-1:0] rdat0_q, rdat0_d;
    logic [DATA_BITS-1:0] rdat1_q, rdat1_d;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        gnt_sel    = 1'b0;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        in_dat_d   = in_dat_q;
        we_d       = we_q;
        cs_d       = cs_q;
        ack0_d     = ack0_q;
        ack1_d     = ack1_q;
        rdat0_d    = rdat0_q;
        rdat1_d    = rdat1_q;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Under contention the port that did not win last time goes first.
                    gnt_sel    = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;
                    gnt_d      = gnt_sel;
                    last_gnt_d = gnt_sel;
                    addr_d     = gnt_sel ? bus.addr1 : bus.addr0;
                    in_dat_d   = gnt_sel ? bus.wdat1 : bus.wdat0;
                    we_d       = gnt_sel ? bus.we1   : bus.we0;
                    cs_d       = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cs_d = 1'b0;
                we_d = 1'b0;
                if (we_q) begin
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = ACK;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (gnt_q) begin
                        rdat1_d = bus.o_dat;
                    end else begin
                        rdat0_d = bus.o_dat;
                    end
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ACK: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            cnt_q      <= 2'd0;
            addr_q     <= '0;
            in_dat_q   <= '0;
            we_q       <= 1'b0;
            cs_q       <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdat0_q    <= '0;
            rdat1_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            in_dat_q   <= in_dat_d;
            we_q       <= we_d;
            cs_q       <= cs_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdat0_q    <= rdat0_d;
            rdat1_q    <= rdat1_d;
        end
    end

    assign bus.addr      = addr_q;
    assign bus.in_dat    = in_dat_q;
    assign bus.WE        = we_q;
    assign bus.CS        = cs_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdat0     = rdat0_q;
    assign bus.rdat1     = rdat1_q;
    assign bus.dbg_state = state_q;
endmodule
